// File: rtl/shreg_pkg.sv
// Shared definitions for the multi-stage shift register: the op encoding and the
// legal range of the DEPTH parameter.
package shreg_pkg;

    typedef enum logic [1:0] {
        OP_HOLD  = 2'd0,
        OP_SHIFT = 2'd1,
        OP_LOAD  = 2'd2,
        OP_CLEAR = 2'd3
    } shreg_op_e;

    localparam int SHREG_DEPTH_MIN = 2;
    localparam int SHREG_DEPTH_MAX = 64;

endpackage

// File: rtl/shreg_if.sv
// Control/data bundle for shreg_multi. par_in exists only when SHREG_PAR_LOAD_EN
// is defined.
interface shreg_if
    import shreg_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
);
    shreg_op_e              op;
    logic [WIDTH-1:0]       data_in;
    logic                   in_valid;
`ifdef SHREG_PAR_LOAD_EN
    logic [DEPTH*WIDTH-1:0] par_in;
`endif
    logic [WIDTH-1:0]       data_out;
    logic                   out_valid;
    logic [DEPTH*WIDTH-1:0] taps;
    logic                   full;
    logic                   empty;

    modport master (
        output op, data_in, in_valid,
`ifdef SHREG_PAR_LOAD_EN
        output par_in,
`endif
        input  data_out, out_valid, taps, full, empty
    );

    modport slave (
        input  op, data_in, in_valid,
`ifdef SHREG_PAR_LOAD_EN
        input  par_in,
`endif
        output data_out, out_valid, taps, full, empty
    );
endinterface

// File: rtl/shreg_stage.sv
// One shift-register stage: a WIDTH-bit word plus its valid flag.
// Priority: reset/clear, then parallel load, then shift enable, else hold.
module shreg_stage #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] d_word,
    input  logic             d_valid,
    input  logic [WIDTH-1:0] ld_word,
    output logic [WIDTH-1:0] q_word,
    output logic             q_valid
);
    logic [WIDTH-1:0] word_reg;
    logic             valid_reg;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            word_reg  <= '0;
            valid_reg <= 1'b0;
        end else if (load) begin
            word_reg  <= ld_word;
            valid_reg <= 1'b1;
        end else if (en) begin
            word_reg  <= d_word;
            valid_reg <= d_valid;
        end
    end

    assign q_word  = word_reg;
    assign q_valid = valid_reg;
endmodule

// File: rtl/shreg_multi.sv
// DEPTH-stage shift register of WIDTH-bit words with per-stage valid flags.
// Define SHREG_PAR_LOAD_EN to enable the par_in port and the LOAD operation.
module shreg_multi
    import shreg_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input logic    clk,
    input logic    reset,
    shreg_if.slave bus
);
    generate
        if (DEPTH < SHREG_DEPTH_MIN || DEPTH > SHREG_DEPTH_MAX) begin : g_bad_depth
            $error("shreg_multi: DEPTH out of legal range");
        end
    endgenerate

    logic                   do_shift;
    logic                   do_load;
    logic                   do_clear;
    logic [WIDTH-1:0]       word_q [DEPTH];
    logic [DEPTH-1:0]       valid_q;
    logic [DEPTH*WIDTH-1:0] taps_next;

    assign do_shift = (bus.op == OP_SHIFT);
    assign do_clear = (bus.op == OP_CLEAR);
`ifdef SHREG_PAR_LOAD_EN
    assign do_load  = (bus.op == OP_LOAD);
`else
    // Without the parallel port, LOAD degenerates to HOLD.
    assign do_load  = 1'b0;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [WIDTH-1:0] d_word;
            logic             d_valid;
            logic [WIDTH-1:0] ld_word;

            if (gi == 0) begin : g_head
                assign d_word  = bus.data_in;
                assign d_valid = bus.in_valid;
            end else begin : g_body
                assign d_word  = word_q[gi-1];
                assign d_valid = valid_q[gi-1];
            end

`ifdef SHREG_PAR_LOAD_EN
            assign ld_word = bus.par_in[gi*WIDTH +: WIDTH];
`else
            assign ld_word = '0;
`endif

            shreg_stage #(
                .WIDTH (WIDTH)
            ) u_stage (
                .clk     (clk),
                .reset   (reset),
                .en      (do_shift),
                .load    (do_load),
                .clear   (do_clear),
                .d_word  (d_word),
                .d_valid (d_valid),
                .ld_word (ld_word),
                .q_word  (word_q[gi]),
                .q_valid (valid_q[gi])
            );
        end
    endgenerate

    always_comb begin
        taps_next = '0;
        for (int k = 0; k < DEPTH; k++) begin
            taps_next[k*WIDTH +: WIDTH] = word_q[k];
        end
    end

    // Outputs are pure decodes of stage state; nothing flows through from inputs.
    assign bus.taps      = taps_next;
    assign bus.data_out  = word_q[DEPTH-1];
    assign bus.out_valid = valid_q[DEPTH-1];
    assign bus.full      = &valid_q;
    assign bus.empty     = ~|valid_q;
endmodule

// File: doc/shreg_multi.md
SHREG_MULTI -- requirements
Module: shreg_multi

Interface
REQ-001 Parameter WIDTH, default 1, bits per stage word.
REQ-002 Parameter DEPTH, default 4, number of stages; legal range 2..64.
REQ-003 Port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port op  input  2  operation select: HOLD=0, SHIFT=1, LOAD=2, CLEAR=3.
REQ-006 Port data_in  input  WIDTH  serial word entering stage 0 on SHIFT.
REQ-007 Port in_valid  input  1  qualifies data_in on SHIFT.
REQ-008 Port par_in  input  DEPTH*WIDTH  parallel load image, stage k at bits [k*WIDTH +: WIDTH] (present only with SHREG_PAR_LOAD_EN).
REQ-009 Port data_out  output  WIDTH  contents of stage DEPTH-1.
REQ-010 Port out_valid  output  1  valid flag of stage DEPTH-1.
REQ-011 Port taps  output  DEPTH*WIDTH  all stage contents, same packing as par_in.
REQ-012 Port full  output  1  all DEPTH valid flags set.
REQ-013 Port empty  output  1  no valid flag set.

Function
REQ-014 Each stage SHALL hold a WIDTH-bit word plus one valid flag; all outputs SHALL be registered state or direct decodes of it, with no combinational path from inputs to outputs.
REQ-015 HOLD: stage words and valid flags SHALL remain unchanged.
REQ-016 SHIFT: stage k+1 SHALL take stage k (word and flag) for k=0..DEPTH-2; stage 0 SHALL take data_in with flag = in_valid; prior stage DEPTH-1 contents SHALL be discarded.
REQ-017 SHIFT with in_valid=0 SHALL still advance the pipeline, inserting a bubble (flag 0, word = data_in as driven).
REQ-018 Latency: a word accepted on SHIFT SHALL appear on data_out with out_valid=1 after exactly DEPTH SHIFT cycles; HOLD cycles SHALL stall without loss.
REQ-019 LOAD: stage k SHALL take par_in slice k and all valid flags SHALL be set to 1.
REQ-020 CLEAR: all words and valid flags SHALL go to 0 on the next edge.
REQ-021 full and empty SHALL be decoded from the valid flags of the same cycle; with DEPTH stages both SHALL never be 1 simultaneously.
REQ-022 With WIDTH=1, DEPTH=4, op held at SHIFT and in_valid=1, data_out SHALL equal data_in delayed by 4 cycles.

Reset
REQ-023 reset=1 at a rising edge SHALL zero every stage word and valid flag, overriding any op value.
REQ-024 After reset: data_out=0, out_valid=0, taps=0, full=0, empty=1.
REQ-025 reset asserted mid-stream SHALL discard all in-flight words; no word accepted before reset SHALL emerge afterwards.

Configuration
REQ-026 Macro SHREG_PAR_LOAD_EN defined: par_in port exists and LOAD behaves per REQ-019.
REQ-027 Macro SHREG_PAR_LOAD_EN undefined: par_in port absent and op=LOAD SHALL behave exactly as HOLD.

Structure
REQ-028 Package shreg_pkg SHALL hold the op encoding typedef (HOLD, SHIFT, LOAD, CLEAR) and the DEPTH legal-range constants.
REQ-029 One sub-module shreg_stage (WIDTH-bit word + valid flag, load/clear/enable inputs) SHALL be instantiated DEPTH times by a generate loop.

Verification
REQ-030 Reset: assert reset 2 cycles with op=SHIFT, data_in=1 -> data_out=0, out_valid=0, empty=1, taps=0.
REQ-031 Latency: WIDTH=8, DEPTH=4, SHIFT 0x11,0x22,0x33,0x44 then 0x00 with in_valid=0 -> data_out 0x11 valid on cycle 4, 0x44 on cycle 7, full=1 after cycle 4, out_valid=0 on cycle 8.
REQ-032 Stall and bubbles: SHIFT 0xA5, HOLD 3 cycles, SHIFT 3 bubbles -> 0xA5 emerges valid after 4 SHIFTs total, only one valid output, empty=1 after next SHIFT.
REQ-033 LOAD (macro on): par_in=0x44332211 -> taps=0x44332211, data_out=0x44, full=1; then 4 bubble SHIFTs -> empty=1; macro off: same stimulus -> state unchanged.
REQ-034 CLEAR while full -> next cycle empty=1, out_valid=0, taps=0.
REQ-035 Mid-stream reset: 2 words in flight, reset 1 cycle, 4 bubble SHIFTs -> out_valid never 1.
